vga_sync_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_sync_gen_if.sv | 28 ++
 rtl/vga_pix_div.sv | 46 ++++
 rtl/vga_sync_gen.sv | 130 +++++++++++++
 tb/tb_vga_sync_gen.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, colour constants and window helper
//
// Holds the default 640x480@60 timing (25 MHz pixel rate) used by the sync
// generator and the 12-bit RGB colour constants shared with the pixel painter.

package vga_pkg;

    // Horizontal timing, in pixels (hCount counts 0..H_TOTAL-1).
    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_VIS_START = 144;
    localparam int H_VIS_END   = 784;

    // Vertical timing, in lines (vCount counts 0..V_TOTAL-1).
    localparam int V_TOTAL     = 525;
    localparam int V_SYNC      = 2;
    localparam int V_VIS_START = 35;
    localparam int V_VIS_END   = 515;

    // 12-bit colours, 4 bits per channel, {R,G,B}.
    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;
    localparam logic [11:0] RED   = 12'hF00;
    localparam logic [11:0] GREEN = 12'h0F0;
    localparam logic [11:0] BLUE  = 12'h00F;

    // True when lo <= x < hi.
    function automatic logic in_range(input logic [9:0] x, input int lo, input int hi);
        return (int'(x) >= lo) && (int'(x) < hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - timing bundle from the sync generator to the painter and pins
//
// master: the sync generator drives every signal.
// slave : the painter / top-level pins observe them.
// Signals: pixel_en, hCount[9:0], vCount[9:0], hSync, vSync, bright,
//          line_tick, frame_tick, frame_count[15:0].

interface vga_sync_gen_if;
    logic        pixel_en;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        hSync;
    logic        vSync;
    logic        bright;
    logic        line_tick;
    logic        frame_tick;
    logic [15:0] frame_count;

    modport master (
        output pixel_en, hCount, vCount, hSync, vSync, bright,
               line_tick, frame_tick, frame_count
    );

    modport slave (
        input  pixel_en, hCount, vCount, hSync, vSync, bright,
               line_tick, frame_tick, frame_count
    );
endinterface

// File: rtl/vga_pix_div.sv
// rtl/vga_pix_div.sv - board-clock to pixel-rate divider
//
// Ports:
//   clk      in   board clock
//   reset    in   synchronous, active-high
//   pixel_en out  registered strobe, high one clk in every CLK_DIV
//   div_last out  combinational, high on the clk whose edge advances the counters

module vga_pix_div
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pixel_en,
    output logic div_last
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pixel_en_q, pixel_en_d;

    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d      = div_last ? '0 : div_q + 1'b1;
        // pixel_en appears the clk after div reaches its last value, the same
        // edge the counters move on, so the strobe marks a fresh pixel.
        pixel_en_d = div_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            pixel_en_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            pixel_en_q <= pixel_en_d;
        end
    end

    assign pixel_en = pixel_en_q;

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA horizontal/vertical timing generator
//
// Ports:
//   clk    in      board clock (100 MHz)
//   reset  in      synchronous, active-high; overrides every other update
//   vga    master  pixel_en, hCount, vCount, hSync/vSync (active low), bright,
//                  line_tick, frame_tick, frame_count
// Build option: VGA_FRAME_CNT_EN - when defined, frame_count counts frame_ticks
// (wrapping at 16 bits); otherwise it is tied to zero.

module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = vga_pkg::H_TOTAL,
    parameter int H_SYNC      = vga_pkg::H_SYNC,
    parameter int H_VIS_START = vga_pkg::H_VIS_START,
    parameter int H_VIS_END   = vga_pkg::H_VIS_END,
    parameter int V_TOTAL     = vga_pkg::V_TOTAL,
    parameter int V_SYNC      = vga_pkg::V_SYNC,
    parameter int V_VIS_START = vga_pkg::V_VIS_START,
    parameter int V_VIS_END   = vga_pkg::V_VIS_END
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);

    logic       div_last;
    logic       pixel_en;

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       bright_q, bright_d;
    logic       line_tick_q, line_tick_d;
    logic       frame_tick_q, frame_tick_d;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk      (clk),
        .reset    (reset),
        .pixel_en (pixel_en),
        .div_last (div_last)
    );

    always_comb begin
        h_d          = h_q;
        v_d          = v_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        bright_d     = bright_q;
        line_tick_d  = 1'b0;
        frame_tick_d = 1'b0;

        if (div_last) begin
            if (h_q == 10'(H_TOTAL - 1)) begin
                h_d         = '0;
                line_tick_d = 1'b1;
                if (v_q == 10'(V_TOTAL - 1)) begin
                    v_d          = '0;
                    frame_tick_d = 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end

            // Decode from the next counts so sync/bright land on the same edge
            // as the counters they describe.
            hsync_d  = (int'(h_d) >= H_SYNC);
            vsync_d  = (int'(v_d) >= V_SYNC);
            bright_d = in_range(h_d, H_VIS_START, H_VIS_END) &&
                       in_range(v_d, V_VIS_START, V_VIS_END);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q          <= '0;
            v_q          <= '0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            bright_q     <= 1'b0;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            bright_q     <= bright_d;
            line_tick_q  <= line_tick_d;
            frame_tick_q <= frame_tick_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_tick_d ? frame_count_q + 16'd1 : frame_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign vga.frame_count = frame_count_q;
`else
    assign vga.frame_count = 16'd0;
`endif

    assign vga.pixel_en   = pixel_en;
    assign vga.hCount     = h_q;
    assign vga.vCount     = v_q;
    assign vga.hSync      = hsync_q;
    assign vga.vSync      = vsync_q;
    assign vga.bright     = bright_q;
    assign vga.line_tick  = line_tick_q;
    assign vga.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen (default and scaled timing)

module tb_vga_sync_gen;

    // Scaled timing so whole frames fit in a short run.
    localparam int S_DIV = 3, S_HT = 40, S_HS = 5, S_HVS = 8, S_HVE = 36;
    localparam int S_VT = 20, S_VS = 2, S_VVS = 4, S_VVE = 18;
    localparam int S_FRAME = S_DIV * S_HT * S_VT;

    logic clk = 1'b0;
    logic reset = 1'b1;

    vga_sync_gen_if if_d ();
    vga_sync_gen_if if_s ();

    vga_sync_gen u_dut_d (
        .clk   (clk),
        .reset (reset),
        .vga   (if_d.master)
    );

    vga_sync_gen #(
        .CLK_DIV (S_DIV), .H_TOTAL (S_HT), .H_SYNC (S_HS),
        .H_VIS_START (S_HVS), .H_VIS_END (S_HVE),
        .V_TOTAL (S_VT), .V_SYNC (S_VS),
        .V_VIS_START (S_VVS), .V_VIS_END (S_VVE)
    ) u_dut_s (
        .clk   (clk),
        .reset (reset),
        .vga   (if_s.master)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    int   n = 0;            // clk edges since reset was last released
    int   last_ft_s = 0;
    int   last_lt_d = 0;
    logic prev_hs_d = 1'b0;

    task automatic cmp(input string tag, input logic [31:0] obs, input int exp);
        vectors++;
        assert (obs === 32'(exp)) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the number of pixel steps taken is n/D, so every output is
    // plain arithmetic on that step count.
    task automatic check_model(input string who,
                               input int D, input int HT, input int HS, input int HVS, input int HVE,
                               input int VT, input int VS, input int VVS, input int VVE,
                               input logic pe, input logic [9:0] hc, input logic [9:0] vc,
                               input logic hs, input logic vs, input logic br,
                               input logic lt, input logic ft, input logic [15:0] fc);
        int p, h, v, e_pe, e_lt, e_ft, e_fc;
        p    = n / D;
        h    = p % HT;
        v    = (p / HT) % VT;
        e_pe = (n > 0 && n % D == 0) ? 1 : 0;
        e_lt = (e_pe == 1 && h == 0) ? 1 : 0;
        e_ft = (e_lt == 1 && v == 0) ? 1 : 0;
`ifdef VGA_FRAME_CNT_EN
        e_fc = (p / (HT * VT)) % 65536;
`else
        e_fc = 0;
`endif
        cmp({who, "_pixel_en"},   32'(pe), e_pe);
        cmp({who, "_hCount"},     32'(hc), h);
        cmp({who, "_vCount"},     32'(vc), v);
        cmp({who, "_hSync"},      32'(hs), (h >= HS) ? 1 : 0);
        cmp({who, "_vSync"},      32'(vs), (v >= VS) ? 1 : 0);
        cmp({who, "_bright"},     32'(br), (h >= HVS && h < HVE && v >= VVS && v < VVE) ? 1 : 0);
        cmp({who, "_line_tick"},  32'(lt), e_lt);
        cmp({who, "_frame_tick"}, 32'(ft), e_ft);
        cmp({who, "_frame_count"}, 32'(fc), e_fc);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) n = 0;
        else       n++;
        @(negedge clk);
        check_model("s", S_DIV, S_HT, S_HS, S_HVS, S_HVE, S_VT, S_VS, S_VVS, S_VVE,
                    if_s.pixel_en, if_s.hCount, if_s.vCount, if_s.hSync, if_s.vSync,
                    if_s.bright, if_s.line_tick, if_s.frame_tick, if_s.frame_count);
        check_model("d", 4, 800, 96, 144, 784, 525, 2, 35, 515,
                    if_d.pixel_en, if_d.hCount, if_d.vCount, if_d.hSync, if_d.vSync,
                    if_d.bright, if_d.line_tick, if_d.frame_tick, if_d.frame_count);
        if (n == 0) begin
            last_ft_s = 0;
            last_lt_d = 0;
        end
        if (if_s.frame_tick === 1'b1) begin
            cmp("s_frame_tick_spacing", 32'(n - last_ft_s), S_FRAME);
            last_ft_s = n;
        end
        if (if_d.line_tick === 1'b1) begin
            cmp("d_line_tick_spacing", 32'(n - last_lt_d), 3200);
            last_lt_d = n;
        end
        if (if_d.hSync === 1'b1 && prev_hs_d === 1'b0) begin
            cmp("d_hsync_low_clks", 32'(n - last_lt_d), 384);
        end
        prev_hs_d = if_d.hSync;
    endtask

    task automatic run_to(input int target);
        while (n < target) tick();
    endtask

    task automatic pulse_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        cmp({tag, "_hCount"},     32'(if_s.hCount), 0);
        cmp({tag, "_vCount"},     32'(if_s.vCount), 0);
        cmp({tag, "_hSync"},      32'(if_s.hSync), 0);
        cmp({tag, "_vSync"},      32'(if_s.vSync), 0);
        cmp({tag, "_bright"},     32'(if_s.bright), 0);
        cmp({tag, "_pixel_en"},   32'(if_s.pixel_en), 0);
        cmp({tag, "_line_tick"},  32'(if_s.line_tick), 0);
        cmp({tag, "_frame_tick"}, 32'(if_s.frame_tick), 0);
        cmp({tag, "_frame_count"}, 32'(if_s.frame_count), 0);
    endtask

    initial begin
        @(negedge clk);
        pulse_reset(3);
        check_reset_state("reset");

        // Visible-window corners of the scaled timing, first frame.
        run_to((3 * S_HT + 8) * S_DIV);
        cmp("bright_8_3", 32'(if_s.bright), 0);
        run_to((4 * S_HT + 7) * S_DIV);
        cmp("bright_7_4", 32'(if_s.bright), 0);
        run_to((4 * S_HT + 8) * S_DIV);
        cmp("bright_8_4", 32'(if_s.bright), 1);
        run_to((17 * S_HT + 35) * S_DIV);
        cmp("bright_35_17", 32'(if_s.bright), 1);
        run_to((17 * S_HT + 36) * S_DIV);
        cmp("bright_36_17", 32'(if_s.bright), 0);
        run_to((18 * S_HT + 8) * S_DIV);
        cmp("bright_8_18", 32'(if_s.bright), 0);

        // Three full frames.
        run_to(3 * S_FRAME);
        cmp("frame_tick_at_3", 32'(if_s.frame_tick), 1);
`ifdef VGA_FRAME_CNT_EN
        cmp("frame_count_3", 32'(if_s.frame_count), 3);
`else
        cmp("frame_count_3", 32'(if_s.frame_count), 0);
`endif

        // One-clk reset mid-frame at (20,10), then a full frame from release.
        run_to(3 * S_FRAME + (10 * S_HT + 20) * S_DIV);
        cmp("pre_reset_hCount", 32'(if_s.hCount), 20);
        cmp("pre_reset_vCount", 32'(if_s.vCount), 10);
        pulse_reset(1);
        check_reset_state("midframe_reset");
        run_to(S_FRAME);
        cmp("frame_tick_after_reset", 32'(if_s.frame_tick), 1);

        // Random run lengths, each ended by a one-clk reset at a random point.
        for (int k = 0; k < 8; k++) begin
            run_to(int'($urandom_range(50, 3000)));
            pulse_reset(1);
            check_reset_state("rand_reset");
        end

        // Long run so the default-timing instance completes two lines and
        // its vSync pulse.
        run_to(7000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
